regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (WriteRegister/WriteData/RegWrite)

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// State and requester encodings used by the top and by rr_arbiter2.
package regfile_write_arbiter_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a single priority-pointer flop.
// The pointer moves only when both requesters competed in an enabled cycle.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic valid_a,
  input  logic valid_b,
  output logic ready_a,
  output logic ready_b
);

  req_id_e ptr_q;

  always_comb begin
    ready_a = enable && valid_a && (!valid_b || ptr_q == REQ_A);
    ready_b = enable && valid_b && (!valid_a || ptr_q == REQ_B);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_A;
    end else if (enable && valid_a && valid_b) begin
      ptr_q <= (ptr_q == REQ_A) ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback.
// Define REGFILE_WRITE_ARBITER_CLEAR_EN to zero registers 1..NUM_REGS-1 after reset.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                NUM_REGS    = NUM_REGS_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              ValidA,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [DATA_W-1:0] DataA,
  output logic              ReadyA,
  input  logic              ValidB,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DataB,
  output logic              ReadyB,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              Busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic              in_clear;
  logic [ADDR_W-1:0] clear_addr;

`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clear_idx_q, clear_idx_d;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= ST_CLEAR;
      clear_idx_q <= ADDR_W'(1);
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clear_idx_d = clear_idx_q + 1'b1;
        if (clear_idx_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign in_clear   = (state_q == ST_CLEAR);
  assign clear_addr = clear_idx_q;
`else
  // Without the clear sequence the arbiter is always serving requesters.
  assign in_clear   = 1'b0;
  assign clear_addr = LAST_IDX;
`endif

  assign Busy = in_clear;

  rr_arbiter2 u_arb (
    .clk     (Clk),
    .rst_n   (ResetN),
    .enable  (!in_clear),
    .valid_a (ValidA),
    .valid_b (ValidB),
    .ready_a (ReadyA),
    .ready_b (ReadyB)
  );

  // Writes to register 0 complete the handshake but never assert RegWrite.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      WriteRegister <= '0;
      WriteData     <= '0;
      RegWrite      <= 1'b0;
    end else if (in_clear) begin
      WriteRegister <= clear_addr;
      WriteData     <= CLEAR_VALUE;
      RegWrite      <= 1'b1;
    end else if (ReadyA) begin
      WriteRegister <= AddrA;
      WriteData     <= DataA;
      RegWrite      <= (AddrA != '0);
    end else if (ReadyB) begin
      WriteRegister <= AddrB;
      WriteData     <= DataB;
      RegWrite      <= (AddrB != '0);
    end else begin
      RegWrite      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sequence (when
// REGFILE_WRITE_ARBITER_CLEAR_EN is defined), grant table, async reset.
module tb_regfile_write_arbiter;

  logic        Clk;
  logic        ResetN;
  logic        ValidA, ValidB;
  logic [4:0]  AddrA, AddrB;
  logic [31:0] DataA, DataB;
  logic        ReadyA, ReadyB;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];

  regfile_write_arbiter dut (
    .Clk           (Clk),
    .ResetN        (ResetN),
    .ValidA        (ValidA),
    .AddrA         (AddrA),
    .DataA         (DataA),
    .ReadyA        (ReadyA),
    .ValidB        (ValidB),
    .AddrB         (AddrB),
    .DataB         (DataB),
    .ReadyB        (ReadyB),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .Busy          (Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Regfile stand-in: captures whatever the arbiter drives into the port.
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'hDEAD_0000 | 32'(i);
  end
  always @(posedge Clk) begin
    if (RegWrite) model[WriteRegister] <= WriteData;
  end

  typedef struct {
    logic        va;
    logic [4:0]  aa;
    logic [31:0] da;
    logic        vb;
    logic [4:0]  ab;
    logic [31:0] db;
    logic        ra;
    logic        rb;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic va, logic [4:0] aa, logic [31:0] da,
                              logic vb, logic [4:0] ab, logic [31:0] db,
                              logic ra, logic rb, logic rw, logic [4:0] wr,
                              logic [31:0] wd);
    vec_t v;
    v.va = va; v.aa = aa; v.da = da;
    v.vb = vb; v.ab = ab; v.db = db;
    v.ra = ra; v.rb = rb; v.rw = rw; v.wr = wr; v.wd = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    ValidA = 1'b0; AddrA = '0; DataA = '0;
    ValidB = 1'b0; AddrB = '0; DataB = '0;
  endtask

  // Clear walk: ValidA is held high to prove it is never granted meanwhile.
  task automatic run_clear(input string tag);
    ValidA = 1'b1; AddrA = 5'd5; DataA = 32'h55;
    for (int i = 1; i <= 31; i++) begin
      #1;
      check($sformatf("%s busy[%0d]", tag, i), 32'(Busy), 32'd1);
      check($sformatf("%s ready_a[%0d]", tag, i), 32'(ReadyA), 32'd0);
      step();
      check($sformatf("%s regwrite[%0d]", tag, i), 32'(RegWrite), 32'd1);
      check($sformatf("%s wreg[%0d]", tag, i), 32'(WriteRegister), 32'(i));
      check($sformatf("%s wdata[%0d]", tag, i), WriteData, 32'h0);
    end
    ValidA = 1'b0;
    #1;
    check($sformatf("%s busy_after", tag), 32'(Busy), 32'd0);
    step();
    check($sformatf("%s regwrite_after", tag), 32'(RegWrite), 32'd0);
  endtask

  initial begin
    // Pointer starts at A; comments give the pointer before each row.
    vecs[0]  = mk(1, 15, 32'h15,   0, 0, 32'h0,      1, 0, 1, 15, 32'h15);   // A
    vecs[1]  = mk(0, 0,  32'h0,    0, 0, 32'h0,      0, 0, 0, 15, 32'h15);   // A
    vecs[2]  = mk(1, 3,  32'h33,   1, 4, 32'h44,     1, 0, 1, 3,  32'h33);   // A
    vecs[3]  = mk(1, 3,  32'h33,   1, 4, 32'h44,     0, 1, 1, 4,  32'h44);   // B
    vecs[4]  = mk(1, 3,  32'h33,   1, 4, 32'h44,     1, 0, 1, 3,  32'h33);   // A
    vecs[5]  = mk(1, 3,  32'h33,   1, 4, 32'h44,     0, 1, 1, 4,  32'h44);   // B
    vecs[6]  = mk(0, 0,  32'h0,    1, 0, 32'hFFFF,   0, 1, 0, 0,  32'hFFFF); // A
    vecs[7]  = mk(0, 0,  32'h0,    1, 9, 32'h99,     0, 1, 1, 9,  32'h99);   // A
    vecs[8]  = mk(1, 7,  32'hAAAA, 1, 7, 32'hBBBB,   1, 0, 1, 7,  32'hAAAA); // A
    vecs[9]  = mk(0, 0,  32'h0,    1, 7, 32'hBBBB,   0, 1, 1, 7,  32'hBBBB); // B
    vecs[10] = mk(1, 7,  32'hAAAA, 1, 7, 32'hBBBB,   0, 1, 1, 7,  32'hBBBB); // B
    vecs[11] = mk(1, 7,  32'hAAAA, 0, 0, 32'h0,      1, 0, 1, 7,  32'hAAAA); // A
    vecs[12] = mk(0, 0,  32'h0,    0, 0, 32'h0,      0, 0, 0, 7,  32'hAAAA); // A

    idle_inputs();
    ResetN = 1'b0;
    #2;
    check("reset wreg", 32'(WriteRegister), 32'h0);
    check("reset wdata", WriteData, 32'h0);
    check("reset regwrite", 32'(RegWrite), 32'h0);
`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
    check("reset busy", 32'(Busy), 32'd1);
`else
    check("reset busy", 32'(Busy), 32'd0);
`endif
    step();
    step();
    ResetN = 1'b1;

`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
    run_clear("clear");
    for (int r = 1; r < 32; r++) check($sformatf("cleared reg%0d", r), model[r], 32'h0);
`else
    step();
    check("run idle regwrite", 32'(RegWrite), 32'd0);
    check("run idle busy", 32'(Busy), 32'd0);
`endif

    for (int i = 0; i < 13; i++) begin
      ValidA = vecs[i].va; AddrA = vecs[i].aa; DataA = vecs[i].da;
      ValidB = vecs[i].vb; AddrB = vecs[i].ab; DataB = vecs[i].db;
      #1;
      check($sformatf("vec%0d ready_a", i), 32'(ReadyA), 32'(vecs[i].ra));
      check($sformatf("vec%0d ready_b", i), 32'(ReadyB), 32'(vecs[i].rb));
      step();
      check($sformatf("vec%0d regwrite", i), 32'(RegWrite), 32'(vecs[i].rw));
      check($sformatf("vec%0d wreg", i), 32'(WriteRegister), 32'(vecs[i].wr));
      check($sformatf("vec%0d wdata", i), WriteData, vecs[i].wd);
    end
    idle_inputs();
    step();

    check("regfile r15", model[15], 32'h15);
    check("regfile r3", model[3], 32'h33);
    check("regfile r4", model[4], 32'h44);
    check("regfile r9", model[9], 32'h99);
    check("regfile r7", model[7], 32'hAAAA);
    check("regfile r0", model[0], 32'hDEAD_0000);

    // Asynchronous reset in the middle of a cycle clears outputs at once.
    ValidA = 1'b1; AddrA = 5'd12; DataA = 32'hC0DE;
    step();
    ValidA = 1'b0;
    #2;
    ResetN = 1'b0;
    #1;
    check("async wreg", 32'(WriteRegister), 32'h0);
    check("async wdata", WriteData, 32'h0);
    check("async regwrite", 32'(RegWrite), 32'h0);
    step();
    ResetN = 1'b1;

`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
    // Partial clear, reset at index 10, then a full restart from reg 1.
    for (int i = 1; i <= 9; i++) step();
    check("mid wreg before", 32'(WriteRegister), 32'd9);
    #2;
    ResetN = 1'b0;
    #1;
    check("mid wreg", 32'(WriteRegister), 32'h0);
    check("mid regwrite", 32'(RegWrite), 32'h0);
    check("mid busy", 32'(Busy), 32'd1);
    step();
    ResetN = 1'b1;
    run_clear("restart");
`else
    ValidB = 1'b1; AddrB = 5'd20; DataB = 32'h20;
    #1;
    check("post reset ready_b", 32'(ReadyB), 32'd1);
    step();
    ValidB = 1'b0;
    check("post reset wreg", 32'(WriteRegister), 32'd20);
    check("post reset regwrite", 32'(RegWrite), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
